// File: rtl/speed_ctrl_pkg.sv
// Shared constants, debounce FSM encoding and the divide-ratio helper for speed_tick_ctrl.
package speed_ctrl_pkg;

  // Mode value that freezes the prescaler and counter.
  localparam int unsigned MODE_STOP = 0;

  typedef enum logic {
    StStable = 1'b0,
    StSettle = 1'b1
  } deb_state_e;

  // log2 of the tick period R(m) for mode m. Mode 1 is the slowest and the top mode runs every
  // cycle. The value returned for mode 0 has no meaning because that mode never ticks.
  function automatic int unsigned log2_ratio(input int unsigned mode,
                                             input int unsigned mode_w,
                                             input int unsigned div_shift);
    return div_shift * (((32'd1 << mode_w) - 32'd1) - mode);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a settle-count debouncer for a bus of switches.
module sw_debounce
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_accepted
);

  localparam int unsigned SET_W = $clog2(DEB_CYC + 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_accepted;
  logic [SET_W-1:0] r_cnt;
  deb_state_e       r_state;

  logic [WIDTH-1:0] w_cand_d;
  logic [WIDTH-1:0] w_accepted_d;
  logic [SET_W-1:0] w_cnt_d;
  deb_state_e       w_state_d;

  // Synchronize the raw switches into the clock domain before anything looks at them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce next-state: any change restarts the settle window; the cycle that loads the
  // candidate already counts as its first stable cycle, so r_cnt holds (stable cycles - 1).
  always_comb begin
    w_state_d    = r_state;
    w_cand_d     = r_cand;
    w_cnt_d      = r_cnt;
    w_accepted_d = r_accepted;
    if (r_sync2 != r_cand) begin
      w_cand_d  = r_sync2;
      w_cnt_d   = '0;
      w_state_d = StSettle;
    end else if (r_state == StSettle) begin
      if (32'(r_cnt) + 32'd2 >= DEB_CYC) begin
        w_accepted_d = r_cand;
        w_cnt_d      = '0;
        w_state_d    = StStable;
      end else begin
        w_cnt_d = r_cnt + SET_W'(1);
      end
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StStable;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_accepted <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cand     <= w_cand_d;
      r_cnt      <= w_cnt_d;
      r_accepted <= w_accepted_d;
    end
  end

  assign o_accepted = r_accepted;

endmodule

// File: rtl/speed_tick_ctrl.sv
// Switch-selected tick generator driving a free-running LED counter.
module speed_tick_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned MODE_W    = 2,
  parameter int unsigned DIV_SHIFT = 2,
  parameter int unsigned CNT_W     = 27,
  parameter int unsigned LED_W     = 4,
  parameter int unsigned DEB_CYC   = 1000000
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic [MODE_W-1:0] sw,
  input  logic              clr,
  output logic [LED_W-1:0]  led,
  output logic              tick,
  output logic [MODE_W-1:0] mode_o
);

  // Mode 1 has the longest period, so it sets the prescaler width.
  localparam int unsigned MAX_LOG = DIV_SHIFT * ((32'd1 << MODE_W) - 32'd2);
  localparam int unsigned PRE_W   = (MAX_LOG > 0) ? MAX_LOG : 1;
  localparam logic [MODE_W-1:0] MODE_STOP_W = MODE_W'(MODE_STOP);

  logic [PRE_W-1:0]  r_presc;
  logic [MODE_W-1:0] r_mode;
  logic              r_tick;
  logic [CNT_W-1:0]  r_cnt;

  logic [MODE_W-1:0] w_accepted;
  logic [PRE_W-1:0]  w_presc_max;
  logic              w_last;
  logic              w_commit;
  logic [PRE_W-1:0]  w_presc_d;
  logic [MODE_W-1:0] w_mode_d;
  logic [CNT_W-1:0]  w_cnt_d;

  sw_debounce #(
    .WIDTH  (MODE_W),
    .DEB_CYC(DEB_CYC)
  ) u_sw_debounce (
    .i_clk     (clk_100mhz),
    .i_rst     (rst),
    .i_sw      (sw),
    .o_accepted(w_accepted)
  );

  // Terminal prescaler value R-1 for the active mode.
  always_comb begin
    w_presc_max = '0;
    if (r_mode != MODE_STOP_W) begin
      w_presc_max = PRE_W'((32'd1 << log2_ratio(32'(r_mode), MODE_W, DIV_SHIFT)) - 32'd1);
    end
  end

  // Mode changes land only at the end of a full period (or at once when stopped), so the
  // first period of the new mode always starts from a cleared prescaler.
  assign w_last   = (r_mode != MODE_STOP_W) && (r_presc == w_presc_max);
  assign w_commit = (w_accepted != r_mode) && (w_last || (r_mode == MODE_STOP_W));

  // Prescaler, mode and counter next-state; clr only touches the counter.
  always_comb begin
    w_presc_d = r_presc;
    w_mode_d  = r_mode;
    w_cnt_d   = r_cnt;
    if (w_commit) begin
      w_presc_d = '0;
      w_mode_d  = w_accepted;
    end else if (w_last) begin
      w_presc_d = '0;
    end else if (r_mode != MODE_STOP_W) begin
      w_presc_d = r_presc + PRE_W'(1);
    end
    if (clr) begin
      w_cnt_d = '0;
    end else if (w_last) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  // Prescaler, mode, tick and counter registers.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_mode  <= '0;
      r_tick  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_presc <= w_presc_d;
      r_mode  <= w_mode_d;
      r_tick  <= w_last;
      r_cnt   <= w_cnt_d;
    end
  end

  assign led    = r_cnt[CNT_W-1 -: LED_W];
  assign tick   = r_tick;
  assign mode_o = r_mode;

endmodule
